median_col_feeder: RTL and testbench
====================================

Name: median_col_feeder

Overview:
- Front end of the fast median filter datapath.
- Accepts a raster pixel stream and buffers two full lines in internal line memories.
- Per accepted pixel, emits one vertically aligned 3-pixel column (rows y-2, y-1, y) to drive the 3-input sort stage's a/b/c inputs.
- Handles frame/line counting, start-of-frame resync and the top-border fill period.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 640, pixels per line (≥3).
- IMG_H, 480, lines per frame (≥3).
- XW, 10, column counter width, ≥ clog2(IMG_W).
- YW, 9, row counter width, ≥ clog2(IMG_H).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- pix_in, input, DATA_W, incoming pixel.
- pix_valid, input, 1, pix_in valid this cycle; no backpressure.
- sof, input, 1, start of frame; qualified by pix_valid; marks pix_in as pixel (0,0).
- col_a, output, DATA_W, pixel at (x, y-2), oldest row.
- col_b, output, DATA_W, pixel at (x, y-1).
- col_c, output, DATA_W, pixel at (x, y), current row.
- col_valid, output, 1, col_a/b/c valid.
- col_x, output, XW, column index of emitted column.
- col_y, output, YW, row index y of emitted column (col_c row).
- line_last, output, 1, with col_valid: col_x == IMG_W-1.
- frame_done, output, 1, one-cycle pulse with the last column of a frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0.
  - x=0, y=0, state IDLE.
  - Line memories are not cleared; their stale contents are never exposed.
- State machine (IDLE, FILL, RUN):
  - IDLE: drop all pixels; pix_valid&sof → accept as (0,0), go to FILL.
  - FILL: y<2; pixels written to line memories, col_valid held 0. On the accepted pixel (IMG_W-1, 1), go to RUN.
  - RUN: every accepted pixel produces a column.
  - Frame end: the accepted pixel (IMG_W-1, IMG_H-1) emits its column with frame_done=1 and line_last=1, then goes to IDLE.
- sof handling:
  - pix_valid&sof in FILL or RUN: abort the current frame and restart at (0,0) in FILL.
  - No frame_done pulse is generated for the aborted frame.
  - sof without pix_valid is ignored.
- Line memories L1 (row y-1) and L2 (row y-2), depth IMG_W, indexed by x. For each accepted pixel:
  - Read old L1[x] and L2[x].
  - Write L2[x] ← old L1[x] and L1[x] ← pix_in in the same cycle (read-before-write).
- Latency: outputs registered; accepted pixel at edge N appears on col_* at edge N+1.
  - col_a = old L2[x], col_b = old L1[x], col_c = pix_in.
  - col_valid is a one-cycle pulse per accepted pixel; 0 on cycles with pix_valid=0. col_* hold their last value when col_valid=0.
- Counters:
  - x increments per accepted pixel.
  - At x=IMG_W-1: x→0 and y increments.
  - At (IMG_W-1, IMG_H-1): y→0.
- Gaps: pix_valid may deassert anywhere; counters and memories hold.
- Borders: rows 0–1 produce no output. Left/right column replication is not done here; the downstream window stage handles it.
- Reset mid-frame: the next frame requires a fresh sof. Output must not show pre-reset memory data until two new lines have filled.
- A memory implementation inferring dual-port or single-port RAM with 1-cycle read is acceptable only if latency and ordering above are preserved exactly.

Test Plan:
- Config IMG_W=4, IMG_H=4. Stream pixels value = 16*y+x, continuous valid, sof on first.
  - Expect 8 columns.
  - First: a=0x00, b=0x10, c=0x20, col_x=0, col_y=2.
  - Last: a=0x13, b=0x23, c=0x33, frame_done=1, line_last=1.
- Same frame with pix_valid toggling 1-0-1-0 → identical column sequence; col_valid only in cycles after accepted pixels.
- Pixels before any sof → no col_valid. Then a frame with sof → output as in scenario 1.
- sof asserted mid-row 2 (at x=2) → no frame_done; counters restart. The next 8 valid pixels produce no output, and the new frame's row 2 gives b/c from new data.
- rst_n low for 1 cycle mid-frame → all outputs 0 next cycle, state IDLE. Subsequent frame: first column exactly matches scenario 1, with no stale values.
- Two back-to-back frames (second sof immediately after the first's last pixel) → 8 columns per frame, one frame_done each. Second frame rows 0–1 produce no output even though memories hold frame-1 data.

Source files
------------

// File: rtl/median_col_feeder.sv
// median_col_feeder: buffers two raster lines and emits a vertical 3-pixel column per accepted pixel
module median_col_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] col_a,
  output logic [DATA_W-1:0] col_b,
  output logic [DATA_W-1:0] col_c,
  output logic              col_valid,
  output logic [XW-1:0]     col_x,
  output logic [YW-1:0]     col_y,
  output logic              line_last,
  output logic              frame_done
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t            r_state, w_nxt;
  logic [XW-1:0]     r_x, w_x;
  logic [YW-1:0]     r_y, w_y;
  logic [DATA_W-1:0] r_l1 [IMG_W];
  logic [DATA_W-1:0] r_l2 [IMG_W];
  logic              w_start, w_acc, w_emit, w_last_x, w_last_y;
  // sof forces the pixel to (0,0) regardless of where the counters stand
  assign w_start  = pix_valid & sof;
  assign w_acc    = pix_valid & (sof | (r_state != IDLE));
  assign w_emit   = pix_valid & ~sof & (r_state == RUN);
  assign w_x      = w_start ? '0 : r_x;
  assign w_y      = w_start ? '0 : r_y;
  assign w_last_x = w_x == XW'(IMG_W - 1);
  assign w_last_y = w_y == YW'(IMG_H - 1);
  always_comb
    w_nxt = !pix_valid ? r_state :
            sof ? FILL :
            (r_state == FILL && w_last_x && w_y == YW'(1)) ? RUN :
            (r_state == RUN && w_last_x && w_last_y) ? IDLE : r_state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_x <= w_last_x ? '0 : w_x + 1'b1;
        r_y <= w_last_x ? (w_last_y ? '0 : w_y + 1'b1) : w_y;
      end
    end
  end
  // read-before-write: the old L1 entry shifts down into L2
  always_ff @(posedge clk) begin
    if (rst_n && w_acc) begin
      r_l2[w_x] <= r_l1[w_x];
      r_l1[w_x] <= pix_in;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_a      <= '0;
      col_b      <= '0;
      col_c      <= '0;
      col_x      <= '0;
      col_y      <= '0;
      col_valid  <= 1'b0;
      line_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_valid  <= w_emit;
      line_last  <= w_emit & w_last_x;
      frame_done <= w_emit & w_last_x & w_last_y;
      if (w_emit) begin
        col_a <= r_l2[w_x];
        col_b <= r_l1[w_x];
        col_c <= pix_in;
        col_x <= w_x;
        col_y <= w_y;
      end
    end
  end
endmodule

// File: tb/tb_median_col_feeder.sv
// tb_median_col_feeder: scoreboard bench for a 4x4 image configuration
module tb_median_col_feeder;
  localparam int W = 4;
  localparam int H = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] col_a, col_b, col_c;
  logic       col_valid, line_last, frame_done;
  logic [1:0] col_x, col_y;
  median_col_feeder #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .XW(2), .YW(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .col_a(col_a), .col_b(col_b), .col_c(col_c), .col_valid(col_valid),
    .col_x(col_x), .col_y(col_y), .line_last(line_last), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int          checks = 0;
  int          errors = 0;
  logic [29:0] q[$];
  logic [7:0]  img [H][W];
  int          mx = 0;
  int          my = 0;
  bit          m_act = 1'b0;
  bit          pend = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // reference model: track frame position and the image written so far
  task automatic send(input bit v, input bit s, input logic [7:0] d);
    @(negedge clk);
    pix_valid = v;
    sof = s;
    pix_in = d;
    pend = 1'b0;
    if (v && (m_act || s)) begin
      if (s) begin
        mx = 0;
        my = 0;
        m_act = 1'b1;
      end
      img[my][mx] = d;
      if (my >= 2) begin
        q.push_back({img[my-2][mx], img[my-1][mx], d, 2'(mx), 2'(my),
                     mx == W-1, mx == W-1 && my == H-1});
        pend = 1'b1;
      end
      if (mx == W-1) begin
        mx = 0;
        if (my == H-1) begin
          my = 0;
          m_act = 1'b0;
        end else my++;
      end else mx++;
    end
  endtask
  task automatic frame(input logic [7:0] base, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      send(1'b1, i == 0, base + 8'(16 * (i / W) + (i % W)));
      if (gaps) send(1'b0, 1'b0, 8'hEE);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    sof = 1'b0;
    pend = 1'b0;
    m_act = 1'b0;
    mx = 0;
    my = 0;
    @(posedge clk);
    #1 check("rst", {col_a, col_b, col_c, col_x, col_y, line_last, frame_done, col_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(posedge clk) begin
    #1;
    check("valid", {31'd0, col_valid}, {31'd0, pend});
    if (col_valid)
      check("col", {2'd0, col_a, col_b, col_c, col_x, col_y, line_last, frame_done},
            {2'd0, q.size() > 0 ? q.pop_front() : 30'bx});
  end
  initial begin
    do_reset();
    frame(8'h00, 1'b0, 16);
    repeat (3) send(1'b0, 1'b0, 8'h00);
    frame(8'h00, 1'b1, 16);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 8'hA0 + 8'(i));
    frame(8'h40, 1'b0, 16);
    frame(8'h80, 1'b0, 10);
    frame(8'hC0, 1'b0, 16);
    frame(8'h10, 1'b0, 9);
    do_reset();
    frame(8'h00, 1'b0, 16);
    frame(8'h30, 1'b0, 16);
    frame(8'h50, 1'b0, 16);
    repeat (4) send(1'b0, 1'b0, 8'h00);
    check("drain", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
